// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with a valid/ready handshake on each side.
// Single-cycle ops (add/sub/logic/shift/upper-immediate) finish one cycle
// after accept. Multiply uses a shift-add loop and divide a restoring loop;
// each retires one bit per cycle over WIDTH cycles. The result and flags are
// held in DONE until the consumer takes them.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   in_valid/in_ready          operation handshake (a, b, alu_ctrl)
//   out_valid/out_ready        result handshake
//   alu_result                 registered result
//   alu_zero/overflow/illegal  registered flags belonging to alu_result
//
// state | meaning
// IDLE  | waiting for an operation; in_ready=1
// MUL   | shift-add multiply, one multiplier bit per cycle
// DIV   | restoring divide, one quotient bit per cycle
// DONE  | result held; out_valid=1 until out_ready
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_result,
  output logic             alu_zero,
  output logic             alu_overflow,
  output logic             alu_illegal
);

  localparam int W = WIDTH;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0001;
  localparam logic [3:0] OP_OR   = 4'b0101;
  localparam logic [3:0] OP_XOR  = 4'b0010;
  localparam logic [3:0] OP_LUI  = 4'b0110;
  localparam logic [3:0] OP_SLL  = 4'b0011;
  localparam logic [3:0] OP_SRL  = 4'b0111;
  localparam logic [3:0] OP_SRA  = 4'b1111;
  localparam logic [3:0] OP_MULL = 4'b1000;
  localparam logic [3:0] OP_MULH = 4'b1001;
  localparam logic [3:0] OP_DIVU = 4'b1010;
  localparam logic [3:0] OP_REMU = 4'b1011;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t         state_q, state_d;
  logic [3:0]     op_q, op_d;
  logic [W-1:0]   opa_q, opa_d;      // multiplicand or divisor
  logic [2*W-1:0] acc_q, acc_d;      // {hi, lo} product or {rem, quotient}
  logic [SHW-1:0] cnt_q, cnt_d;      // iterations left, terminal count at 0
  logic [W-1:0]   result_q, result_d;
  logic           zero_q, zero_d;
  logic           ovf_q, ovf_d;
  logic           ill_q, ill_d;

  logic [W-1:0]   sum_w, diff_w, res;
  logic [SHW-1:0] sh;
  logic           fin;
  logic [W:0]     mul_sum;
  logic [2*W-1:0] mul_next;
  logic [W:0]     div_shift, div_sub;
  logic           div_ge;
  logic [2*W-1:0] div_next;

  always_comb begin
    sum_w  = a + b;
    diff_w = a - b;
    sh     = a[SHW-1:0];

    // Add the multiplicand into the high half when the current multiplier
    // bit is set, then shift the whole accumulator right; the carry lands
    // in the top bit.
    mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opa_q} : {(W+1){1'b0}});
    mul_next = {mul_sum, acc_q[W-1:1]};

    // Shift the next dividend bit into the partial remainder and keep the
    // subtraction only when it does not go negative.
    div_shift = acc_q[2*W-1:W-1];
    div_ge    = (div_shift >= {1'b0, opa_q});
    div_sub   = div_shift - {1'b0, opa_q};
    div_next  = {(div_ge ? div_sub[W-1:0] : div_shift[W-1:0]), acc_q[W-2:0], div_ge};

    state_d  = state_q;
    op_d     = op_q;
    opa_d    = opa_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    ill_d    = ill_q;
    res      = '0;
    fin      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d    = alu_ctrl;
          ovf_d   = 1'b0;
          ill_d   = 1'b0;
          fin     = 1'b1;
          state_d = DONE;
          unique case (alu_ctrl)
            OP_ADD: begin
              res   = sum_w;
              ovf_d = (a[W-1] == b[W-1]) && (sum_w[W-1] != a[W-1]);
            end
            OP_SUB: begin
              res   = diff_w;
              ovf_d = (a[W-1] != b[W-1]) && (diff_w[W-1] != a[W-1]);
            end
            OP_AND: res = a & b;
            OP_OR:  res = a | b;
            OP_XOR: res = a ^ b;
            OP_LUI: res = {b[W/2-1:0], {(W/2){1'b0}}};
            OP_SLL: res = b << sh;
            OP_SRL: res = b >> sh;
            OP_SRA: res = $signed(b) >>> sh;
            OP_MULL, OP_MULH: begin
              fin     = 1'b0;
              opa_d   = a;
              acc_d   = {{W{1'b0}}, b};
              cnt_d   = SHW'(W - 1);
              state_d = MUL;
            end
            OP_DIVU, OP_REMU: begin
              if (b == '0) begin
                res = (alu_ctrl == OP_DIVU) ? {W{1'b1}} : a;
              end else begin
                fin     = 1'b0;
                opa_d   = b;
                acc_d   = {{W{1'b0}}, a};
                cnt_d   = SHW'(W - 1);
                state_d = DIV;
              end
            end
            default: begin
              res   = '0;
              ill_d = 1'b1;
            end
          endcase
        end
      end
      MUL: begin
        acc_d = mul_next;
        cnt_d = cnt_q - SHW'(1);
        if (cnt_q == '0) begin
          cnt_d   = '0;
          fin     = 1'b1;
          res     = (op_q == OP_MULH) ? mul_next[2*W-1:W] : mul_next[W-1:0];
          state_d = DONE;
        end
      end
      DIV: begin
        acc_d = div_next;
        cnt_d = cnt_q - SHW'(1);
        if (cnt_q == '0) begin
          cnt_d   = '0;
          fin     = 1'b1;
          res     = (op_q == OP_DIVU) ? div_next[W-1:0] : div_next[2*W-1:W];
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (fin) begin
      result_d = res;
      zero_d   = (res == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= '0;
      opa_q    <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      opa_q    <= opa_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      ill_q    <= ill_d;
    end
  end

  assign in_ready     = (state_q == IDLE);
  assign out_valid    = (state_q == DONE);
  assign alu_result   = result_q;
  assign alu_zero     = zero_q;
  assign alu_overflow = ovf_q;
  assign alu_illegal  = ill_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: a 32-bit instance exercised with directed and random
// operations against an arithmetic reference model, plus an 8-bit instance
// for the narrow multiply case. Inputs change on the falling edge and
// outputs are sampled there too.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, alu_result;
  logic [3:0]  alu_ctrl;
  logic        alu_zero, alu_overflow, alu_illegal;

  logic        in_valid8, in_ready8, out_valid8, out_ready8;
  logic [7:0]  a8, b8, result8;
  logic [3:0]  ctrl8;
  logic        zero8, ovf8, ill8;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .alu_ctrl(alu_ctrl), .out_valid(out_valid), .out_ready(out_ready),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
    .alu_illegal(alu_illegal)
  );

  alu_seq #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .alu_ctrl(ctrl8), .out_valid(out_valid8), .out_ready(out_ready8),
    .alu_result(result8), .alu_zero(zero8), .alu_overflow(ovf8),
    .alu_illegal(ill8)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: what each opcode means arithmetically, plus its latency.
  task automatic model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] r, output logic z, output logic ov,
                       output logic il, output int lat);
    longint      sx, sy;
    logic [63:0] p;
    int          sh;
    sx  = $signed(x);
    sy  = $signed(y);
    p   = {32'h0, x} * {32'h0, y};
    sh  = int'(x[4:0]);
    r   = '0;
    ov  = 1'b0;
    il  = 1'b0;
    lat = 1;
    case (op)
      4'b0000: begin r = x + y; ov = ((sx + sy) != longint'($signed(r))); end
      4'b0100: begin r = x - y; ov = ((sx - sy) != longint'($signed(r))); end
      4'b0001: r = x & y;
      4'b0101: r = x | y;
      4'b0010: r = x ^ y;
      4'b0110: r = y * 32'h10000;
      4'b0011: r = y << sh;
      4'b0111: r = y >> sh;
      4'b1111: r = 32'($signed(y) >>> sh);
      4'b1000: begin r = p[31:0];  lat = 33; end
      4'b1001: begin r = p[63:32]; lat = 33; end
      4'b1010: if (y == 0) r = 32'hFFFF_FFFF; else begin r = x / y; lat = 33; end
      4'b1011: if (y == 0) r = x;             else begin r = x % y; lat = 33; end
      default: il = 1'b1;
    endcase
    z = (r == 0);
  endtask

  // Issue one op, scramble inputs after accept, measure latency, check the
  // result, optionally hold out_ready low for `hold` cycles, then retire it.
  task automatic issue(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                       input int hold, input string tag);
    logic [31:0] er;
    logic        ez, eo, ei;
    int          elat, lat;
    model(op, x, y, er, ez, eo, ei, elat);
    @(negedge clk);
    check({tag, ".in_ready"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1; a = x; b = y; alu_ctrl = op;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; a = $urandom; b = $urandom; alu_ctrl = 4'($urandom);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check({tag, ".latency"},  64'(lat), 64'(elat));
    check({tag, ".result"},   64'(alu_result), 64'(er));
    check({tag, ".zero"},     64'(alu_zero), 64'(ez));
    check({tag, ".overflow"}, 64'(alu_overflow), 64'(eo));
    check({tag, ".illegal"},  64'(alu_illegal), 64'(ei));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; a = $urandom; b = $urandom; alu_ctrl = 4'b0000;
      @(negedge clk);
      check({tag, ".hold_valid"},  64'(out_valid), 64'd1);
      check({tag, ".hold_ready"},  64'(in_ready), 64'd0);
      check({tag, ".hold_result"}, 64'(alu_result), 64'(er));
      check({tag, ".hold_flags"},  64'({alu_zero, alu_overflow, alu_illegal}), 64'({ez, eo, ei}));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, ".retired"}, 64'({in_ready, out_valid}), 64'b10);
  endtask

  initial begin
    logic [3:0]  op;
    logic [31:0] x, y;
    int          lat;
    bit          seen;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; alu_ctrl = '0;
    in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0; ctrl8 = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("reset.in_ready",  64'(in_ready), 64'd1);
    check("reset.out_valid", 64'(out_valid), 64'd0);
    check("reset.result",    64'(alu_result), 64'd0);
    check("reset.flags",     64'({alu_zero, alu_overflow, alu_illegal}), 64'd0);

    issue(4'b0000, 32'h7FFF_FFFF, 32'h0000_0001, 0, "add_ovf");
    issue(4'b0100, 32'd5, 32'd5, 0, "sub_zero");
    issue(4'b0100, 32'h8000_0000, 32'd1, 0, "sub_ovf");
    issue(4'b1111, 32'd4, 32'h8000_0000, 0, "sra");
    issue(4'b0011, 32'd35, 32'h0000_0001, 0, "sll_mod");
    issue(4'b0110, 32'd0, 32'h1234_ABCD, 0, "lui");
    issue(4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mul_lo");
    issue(4'b1001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mul_hi");
    issue(4'b1010, 32'd100, 32'd7, 0, "divu");
    issue(4'b1011, 32'd100, 32'd7, 0, "remu");
    issue(4'b1010, 32'd9, 32'd0, 0, "divu_by0");
    issue(4'b1011, 32'd9, 32'd0, 0, "remu_by0");
    issue(4'b1100, 32'h1, 32'h2, 0, "illegal");
    issue(4'b0101, 32'hF0F0_0000, 32'h0000_0F0F, 5, "hold");

    for (int n = 0; n < 60; n++) begin
      op = 4'($urandom_range(0, 15));
      x  = $urandom;
      y  = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 7) == 0) y = '0;
      issue(op, x, y, (n % 7 == 0) ? 2 : 0, "random");
    end

    // Narrow instance: 0xFF * 0xFF = 0xFE01.
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      in_valid8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; ctrl8 = (k == 0) ? 4'b1001 : 4'b1000;
      @(posedge clk);
      @(negedge clk);
      in_valid8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
      lat = 1;
      while (!out_valid8 && lat < 100) begin
        @(negedge clk);
        lat++;
      end
      check("mul8.latency", 64'(lat), 64'd9);
      check("mul8.result",  64'(result8), (k == 0) ? 64'hFE : 64'h01);
      check("mul8.flags",   64'({zero8, ovf8, ill8}), 64'd0);
      out_ready8 = 1'b1;
      @(negedge clk);
      out_ready8 = 1'b0;
      check("mul8.retired", 64'(in_ready8), 64'd1);
    end

    // Abort a multiply at iteration 10; the last result is nonzero beforehand.
    issue(4'b0000, 32'h7FFF_FFFF, 32'h0000_0001, 0, "pre_abort");
    @(negedge clk);
    in_valid = 1'b1; a = 32'h1234_5678; b = 32'h9ABC_DEF0; alu_ctrl = 4'b1000;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    check("abort.busy", 64'(in_ready), 64'd0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort.in_ready",  64'(in_ready), 64'd1);
    check("abort.out_valid", 64'(out_valid), 64'd0);
    check("abort.result",    64'(alu_result), 64'd0);
    check("abort.flags",     64'({alu_zero, alu_overflow, alu_illegal}), 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("abort.no_result", 64'(seen), 64'd0);
    issue(4'b0010, 32'hAAAA_5555, 32'hFFFF_0000, 0, "after_abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning datapath width (legal: 8, 16, 32, 64).
REQ-002 SHALL have parameter SHW, default $clog2(WIDTH), meaning shift-amount width.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  meaning synchronous active-low reset.
REQ-005 SHALL have port in_valid  input  1  meaning the operands and opcode are presented.
REQ-006 SHALL have port in_ready  output  1  meaning the block accepts an operation this cycle.
REQ-007 SHALL have port a  input  WIDTH  meaning operand A, also the shift amount source a[SHW-1:0].
REQ-008 SHALL have port b  input  WIDTH  meaning operand B.
REQ-009 SHALL have port alu_ctrl  input  4  meaning the opcode (REQ-016).
REQ-010 SHALL have port out_valid  output  1  meaning the result is held and valid.
REQ-011 SHALL have port out_ready  input  1  meaning the consumer takes the result.
REQ-012 SHALL have port alu_result  output  WIDTH  meaning the registered result.
REQ-013 SHALL have ports alu_zero, alu_overflow, alu_illegal  output  1 each  meaning result==0, signed add/sub overflow, and unsupported opcode.

Function
REQ-014 SHALL capture a, b and alu_ctrl when in_valid and in_ready are both high (accept).
REQ-015 SHALL use FSM states IDLE, MUL, DIV, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-016 SHALL decode opcodes: 0000 add; 0100 sub; 0001 and; 0101 or; 0010 xor; 0110 b[WIDTH/2-1:0] placed in the upper half with the lower half zero; 0011 sll b by a; 0111 srl; 1111 sra; 1000 mul low half; 1001 mul high half (unsigned); 1010 divu quotient; 1011 remu remainder.
REQ-017 SHALL transition single-cycle opcodes IDLE->DONE, giving out_valid on the cycle after accept (latency 1).
REQ-018 SHALL implement mul as an unsigned shift-add with one partial product per cycle: IDLE->MUL, WIDTH cycles in MUL, then DONE; out_valid at accept+WIDTH+1.
REQ-019 SHALL implement divu/remu as a restoring divider with one quotient bit per cycle: IDLE->DIV, WIDTH cycles, then DONE; latency WIDTH+1.
REQ-020 SHALL, for a divisor b==0, go IDLE->DONE directly (latency 1) with quotient all-ones and remainder = a.
REQ-021 SHALL hold alu_result and all flags stable in DONE until out_ready is high; then go DONE->IDLE.
REQ-022 SHALL NOT accept a new operation in the cycle DONE->IDLE occurs; the minimum issue interval is 2 cycles.
REQ-023 SHALL set alu_overflow only for add (operands same sign, result sign differs) and for sub (operand signs differ, result sign differs from A); otherwise 0.
REQ-024 SHALL compute shifts modulo WIDTH using a[SHW-1:0]; sra fills with b[WIDTH-1].
REQ-025 SHALL, for unlisted opcodes, complete with latency 1, alu_result=0, alu_zero=1, alu_illegal=1.
REQ-026 SHALL ignore in_valid while not in IDLE; operands changing mid-operation SHALL NOT affect the result.
REQ-027 SHALL wrap all arithmetic modulo 2^WIDTH; mul high returns bits [2*WIDTH-1:WIDTH] of the full product.

Reset
REQ-028 SHALL, when rst_n is low at a clock edge, enter IDLE and clear alu_result, alu_zero, alu_overflow, alu_illegal, the iteration counter and the working registers to 0; in_ready=1 and out_valid=0 on the following cycle.
REQ-029 SHALL abort an in-flight MUL/DIV on reset with no result produced; reset SHALL take priority over accept and over out_ready.

Verification
REQ-030 SHALL cover (WIDTH=32) add of 0x7FFFFFFF and 0x00000001 -> out_valid 1 cycle after accept, result 0x80000000, overflow=1, zero=0.
REQ-031 SHALL cover sub 5-5 -> result 0, zero=1, overflow=0; sra of 0x80000000 by a=4 -> 0xF8000000.
REQ-032 SHALL cover mul 0xFFFFFFFF*0xFFFFFFFF -> low 0x00000001 and high 0xFFFFFFFE, each at accept+33.
REQ-033 SHALL cover divu 100/7 -> quotient 14 and remu 2 at accept+33; divu 9/0 -> quotient 0xFFFFFFFF at accept+1, and remu 9/0 -> remainder 9.
REQ-034 SHALL cover out_ready held low for 5 cycles in DONE -> result stable and in_ready=0 throughout; in_valid pulsed in that window -> ignored.
REQ-035 SHALL cover rst_n low at MUL iteration 10 -> next cycle IDLE, all outputs 0, no out_valid; WIDTH=8 regression of mul 0xFF*0xFF -> high 0xFE at accept+9.
